// File: rtl/decode_stage.sv
// decode_stage: single-entry pipelined decoder for 9-bit instruction words.
// An accepted non-prefix word appears decoded on the outputs one cycle later
// and is held there until the consumer takes it (valid/ready on both sides).
// Build option DECODE_STAGE_EXT_EN: when defined, 11001xxxx words act as
// immediate-extension prefixes that accumulate into an internal register and
// widen the immediate of the next jump or ldi/sti word. When undefined there
// is no prefix state, 11001xxxx decodes as an all-zero word, and
// ext_used/ext_err stay 0.
module decode_stage #(
    parameter int REG_W    = 4,
    parameter int IMM_W    = 8,
    parameter int LDI_BASE = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] reg0,
    output logic [REG_W-1:0] reg1,
    output logic [IMM_W-1:0] imm,
    output logic             use_imm,
    output logic             use_other_reg_bus,
    output logic             ext_used,
    output logic             ext_err
);

    localparam logic [IMM_W-1:0] LDI_BASE_W = IMM_W'(LDI_BASE);

    logic             accept_s;
    logic             ext_pend_s;
    logic [IMM_W-1:0] ext_val_s;

    // Combinational decode of the presented word
    logic [REG_W-1:0] dec_reg0_s;
    logic [REG_W-1:0] dec_reg1_s;
    logic [IMM_W-1:0] dec_imm_s;
    logic             dec_use_imm_s;
    logic             dec_other_s;
    logic             dec_ext_used_s;
    logic             dec_prefix_s;
    logic             dec_err_s;

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [REG_W-1:0] reg0_q, reg0_d;
    logic [REG_W-1:0] reg1_q, reg1_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             use_imm_q, use_imm_d;
    logic             other_q, other_d;
    logic             ext_used_q, ext_used_d;
    logic             ext_err_q, ext_err_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_s = in_valid && in_ready;

`ifdef DECODE_STAGE_EXT_EN
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        EXT_PEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IMM_W-1:0] ext_q, ext_d;

    assign ext_pend_s = (state_q == EXT_PEND);
    assign ext_val_s  = ext_q;

    // Prefix FSM next state: flush clears, prefixes accumulate, anything else ends the chain
    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        if (flush) begin
            state_d = IDLE;
            ext_d   = '0;
        end else if (accept_s) begin
            if (dec_prefix_s) begin
                state_d = EXT_PEND;
                ext_d   = ext_pend_s ? ((ext_q << 3'd4) | IMM_W'(instr[3:0]))
                                     : IMM_W'(instr[3:0]);
            end else begin
                state_d = IDLE;
                ext_d   = '0;
            end
        end else begin
            state_d = state_q;
            ext_d   = ext_q;
        end
    end

    // Prefix FSM state and accumulated extension bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ext_q   <= '0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
        end
    end
`else
    assign ext_pend_s = 1'b0;
    assign ext_val_s  = '0;
`endif

    // Instruction decode; a pending prefix widens jump/ldi immediates and flags anything else
    always_comb begin
        dec_reg0_s     = '0;
        dec_reg1_s     = '0;
        dec_imm_s      = '0;
        dec_use_imm_s  = 1'b0;
        dec_other_s    = 1'b0;
        dec_ext_used_s = 1'b0;
        dec_prefix_s   = 1'b0;
        dec_err_s      = ext_pend_s;
        casez (instr)
            9'b00???????: begin
                dec_reg0_s = REG_W'(instr[5:3]);
                dec_reg1_s = REG_W'(instr[2:0]);
            end
            9'b01???????: begin
                dec_reg0_s = REG_W'(instr[3:2]);
                dec_reg1_s = REG_W'(instr[1:0]);
            end
            9'b100??????: begin
                dec_imm_s      = ext_pend_s ? ((ext_val_s << 3'd4) | IMM_W'(instr[3:0]))
                                            : IMM_W'(instr[3:0]);
                dec_use_imm_s  = 1'b1;
                dec_ext_used_s = ext_pend_s;
                dec_err_s      = 1'b0;
            end
            9'b101010???: begin
                dec_reg1_s = REG_W'(instr[2:0]);
            end
            9'b10100????, 9'b101011???, 9'b10110????: begin
                dec_reg0_s = REG_W'(instr[2:0]);
            end
            9'b101110???: begin
                dec_reg1_s  = REG_W'(instr[2:0]);
                dec_other_s = 1'b1;
            end
            9'b101111???: begin
                dec_reg0_s  = REG_W'(instr[2:0]);
                dec_other_s = 1'b1;
            end
            9'b11000????: begin
                dec_imm_s      = LDI_BASE_W + (ext_pend_s ? ((ext_val_s << 2'd3) | IMM_W'(instr[2:0]))
                                                          : IMM_W'(instr[2:0]));
                dec_use_imm_s  = 1'b1;
                dec_ext_used_s = ext_pend_s;
                dec_err_s      = 1'b0;
            end
            9'b11001????: begin
`ifdef DECODE_STAGE_EXT_EN
                dec_prefix_s = 1'b1;
                dec_err_s    = 1'b0;
`else
                dec_prefix_s = 1'b0;
`endif
            end
            default: begin
                dec_prefix_s = 1'b0;
            end
        endcase
    end

    // Output register next state: flush drops, non-prefix accept loads, consumer drains
    always_comb begin
        out_valid_d = out_valid_q;
        reg0_d      = reg0_q;
        reg1_d      = reg1_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        other_d     = other_q;
        ext_used_d  = ext_used_q;
        ext_err_d   = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s && !dec_prefix_s) begin
            out_valid_d = 1'b1;
            reg0_d      = dec_reg0_s;
            reg1_d      = dec_reg1_s;
            imm_d       = dec_imm_s;
            use_imm_d   = dec_use_imm_s;
            other_d     = dec_other_s;
            ext_used_d  = dec_ext_used_s;
            ext_err_d   = dec_err_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            reg0_q      <= '0;
            reg1_q      <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            other_q     <= 1'b0;
            ext_used_q  <= 1'b0;
            ext_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            reg0_q      <= reg0_d;
            reg1_q      <= reg1_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            other_q     <= other_d;
            ext_used_q  <= ext_used_d;
            ext_err_q   <= ext_err_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign reg0              = reg0_q;
    assign reg1              = reg1_q;
    assign imm               = imm_q;
    assign use_imm           = use_imm_q;
    assign use_other_reg_bus = other_q;
    assign ext_used          = ext_used_q;
    assign ext_err           = ext_err_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (default parameters). Expected decode
// results are pushed to a scoreboard as words are accepted; a monitor records
// every consumed output and each test compares the two queues.
module tb_decode_stage;

    typedef struct packed {
        logic [3:0] r0;
        logic [3:0] r1;
        logic [7:0] imm;
        logic       ui;
        logic       uo;
        logic       eu;
    } exp_t;

`ifdef DECODE_STAGE_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] instr;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] reg0;
    logic [3:0] reg1;
    logic [7:0] imm;
    logic       use_imm;
    logic       use_other_reg_bus;
    logic       ext_used;
    logic       ext_err;

    int   vectors     = 0;
    int   miscompares = 0;
    int   err_pulses  = 0;
    exp_t sb[$];
    exp_t obs[$];

    decode_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .instr             (instr),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .reg0              (reg0),
        .reg1              (reg1),
        .imm               (imm),
        .use_imm           (use_imm),
        .use_other_reg_bus (use_other_reg_bus),
        .ext_used          (ext_used),
        .ext_err           (ext_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] r0, input logic [3:0] r1, input logic [7:0] im,
                                input logic ui, input logic uo, input logic eu);
        exp_t e;
        e.r0 = r0; e.r1 = r1; e.imm = im; e.ui = ui; e.uo = uo; e.eu = eu;
        return e;
    endfunction

    // Records every output the consumer takes and counts ext_err cycles
    task automatic monitor();
        exp_t o;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                o = {reg0, reg1, imm, use_imm, use_other_reg_bus, ext_used};
                obs.push_back(o);
            end
            if (rst_n === 1'b1 && ext_err === 1'b1) err_pulses++;
        end
    endtask

    // Presents one word (entered and left at posedge+2); waits a bounded time for in_ready
    task automatic send(input logic [8:0] ins, input logic want, input exp_t e);
        int w = 0;
        in_valid = 1'b1;
        instr    = ins;
        #1;
        while (in_ready !== 1'b1 && w < 40) begin
            @(posedge clk); #3;
            w++;
        end
        if (in_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready=%b for instr %b, required 1", in_ready, ins);
        end else if (want) begin
            sb.push_back(e);
        end
        @(posedge clk); #2;
    endtask

    // Stops driving and waits (bounded) for outstanding outputs to be consumed
    task automatic settle();
        int w = 0;
        in_valid = 1'b0;
        while (obs.size() < sb.size() && w < 30) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instr = 9'd0;
        #3;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        vectors++;
        if ({reg0, reg1, imm, use_imm, use_other_reg_bus, ext_used, ext_err} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_fields: got %h, required 0",
                     {reg0, reg1, imm, use_imm, use_other_reg_bus, ext_used, ext_err});
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1; out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        out_ready = 1'b0;
        send(9'b000110101, 1'b0, mk(4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || reg0 !== 4'd6 || reg1 !== 4'd5) begin
            miscompares++;
            $display("FAIL held_before_reset: got v=%b r0=%0d r1=%0d, required v=1 r0=6 r1=5", out_valid, reg0, reg1);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || reg0 !== 4'd0 || reg1 !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b r0=%0d r1=%0d, required all 0", out_valid, reg0, reg1);
        end
        @(posedge clk); #2;
        rst_n = 1'b1; out_ready = 1'b1;
        // a prefix cut off by reset must not widen the next jump
        send(9'b110010111, 1'b0, mk(4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        send(9'b100000110, 1'b1, mk(4'd0, 4'd0, 8'd6, 1'b1, 1'b0, 1'b0));
        settle();
        vectors++;
        if (obs.size() != sb.size()) begin
            miscompares++; $display("FAIL reset_mid_count: got %0d outputs, required %0d", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL reset_mid_fields: got %h, required %h", o, e);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_decode_back_to_back();
        logic [8:0] ins [13] = '{9'b000101011, 9'b011101110, 9'b100101101, 9'b101010110,
                                 9'b101000101, 9'b101011011, 9'b101100111, 9'b101110010,
                                 9'b101111100, 9'b110000101, 9'b111010101, 9'b110101111,
                                 9'b010111111};
        exp_t ex [13];
        exp_t e, o;
        ex[0]  = mk(4'd5, 4'd3, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[1]  = mk(4'd3, 4'd2, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[2]  = mk(4'd0, 4'd0, 8'd13, 1'b1, 1'b0, 1'b0);
        ex[3]  = mk(4'd0, 4'd6, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[4]  = mk(4'd5, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[5]  = mk(4'd3, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[6]  = mk(4'd7, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[7]  = mk(4'd0, 4'd2, 8'd0,  1'b0, 1'b1, 1'b0);
        ex[8]  = mk(4'd4, 4'd0, 8'd0,  1'b0, 1'b1, 1'b0);
        ex[9]  = mk(4'd0, 4'd0, 8'd69, 1'b1, 1'b0, 1'b0);
        ex[10] = mk(4'd0, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[11] = mk(4'd0, 4'd0, 8'd0,  1'b0, 1'b0, 1'b0);
        ex[12] = mk(4'd3, 4'd3, 8'd0,  1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) send(ins[i], 1'b1, ex[i]);
        settle();
        vectors++;
        if (obs.size() != sb.size()) begin
            miscompares++; $display("FAIL decode_count: got %0d outputs, required %0d", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL decode_fields: got %h, required %h", o, e);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_backpressure();
        exp_t e, o;
        out_ready = 1'b1;
        send(9'b000011100, 1'b1, mk(4'd3, 4'd4, 8'd0, 1'b0, 1'b0, 1'b0));
        out_ready = 1'b0;
        instr     = 9'b001100001;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || reg0 !== 4'd3 || reg1 !== 4'd4) begin
                miscompares++;
                $display("FAIL stall_hold: got rdy=%b v=%b r0=%0d r1=%0d, required rdy=0 v=1 r0=3 r1=4",
                         in_ready, out_valid, reg0, reg1);
            end
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL stall_release: in_ready=%b, required 1", in_ready);
        end
        sb.push_back(mk(4'd4, 4'd1, 8'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #2;
        settle();
        vectors++;
        if (obs.size() != sb.size()) begin
            miscompares++; $display("FAIL stall_count: got %0d outputs, required %0d", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL stall_fields: got %h, required %h", o, e);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_flush();
        exp_t e, o;
        int   err0;
        out_ready = 1'b0;
        send(9'b000001010, 1'b0, mk(4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL flush_pre_valid: got %b, required 1", out_valid);
        end
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; instr = 9'b000111111;
        @(posedge clk); #2;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_drop: out_valid=%b, required 0", out_valid);
        end
        @(posedge clk); #2;
        err0 = err_pulses;
        send(9'b110010011, 1'b0, mk(4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        flush = 1'b1; in_valid = 1'b1; instr = 9'b110010111;
        @(posedge clk); #2;
        flush = 1'b0;
        send(9'b100000001, 1'b1, mk(4'd0, 4'd0, 8'd1, 1'b1, 1'b0, 1'b0));
        settle();
        vectors++;
        if (err_pulses !== err0) begin
            miscompares++; $display("FAIL flush_ext_err: got %0d pulses, required 0", err_pulses - err0);
        end
        vectors++;
        if (obs.size() != sb.size()) begin
            miscompares++; $display("FAIL flush_count: got %0d outputs, required %0d", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL flush_fields: got %h, required %h", o, e);
            end
        end
        sb.delete(); obs.delete();
    endtask

    task automatic test_prefix();
        exp_t e, o;
        exp_t z;
        int   err0;
        z = mk(4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        err0 = err_pulses;
        send(9'b110010011, !EXT, z);
        send(9'b100001010, 1'b1, EXT ? mk(4'd0, 4'd0, 8'h3A, 1'b1, 1'b0, 1'b1)
                                     : mk(4'd0, 4'd0, 8'h0A, 1'b1, 1'b0, 1'b0));
        send(9'b110010001, !EXT, z);
        send(9'b110010010, !EXT, z);
        send(9'b110000001, 1'b1, EXT ? mk(4'd0, 4'd0, 8'hD1, 1'b1, 1'b0, 1'b1)
                                     : mk(4'd0, 4'd0, 8'h41, 1'b1, 1'b0, 1'b0));
        send(9'b110010001, !EXT, z);
        send(9'b110010010, !EXT, z);
        send(9'b110010011, !EXT, z);
        send(9'b100000100, 1'b1, EXT ? mk(4'd0, 4'd0, 8'h34, 1'b1, 1'b0, 1'b1)
                                     : mk(4'd0, 4'd0, 8'h04, 1'b1, 1'b0, 1'b0));
        send(9'b110010101, !EXT, z);
        send(9'b000000001, 1'b1, mk(4'd0, 4'd1, 8'd0, 1'b0, 1'b0, 1'b0));
        send(9'b110010000, !EXT, z);
        send(9'b111000000, 1'b1, z);
        send(9'b100000010, 1'b1, mk(4'd0, 4'd0, 8'd2, 1'b1, 1'b0, 1'b0));
        settle();
        vectors++;
        if (err_pulses - err0 !== (EXT ? 2 : 0)) begin
            miscompares++;
            $display("FAIL prefix_ext_err: got %0d pulse cycles, required %0d", err_pulses - err0, EXT ? 2 : 0);
        end
        vectors++;
        if (obs.size() != sb.size()) begin
            miscompares++; $display("FAIL prefix_count: got %0d outputs, required %0d", obs.size(), sb.size());
        end
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++; $display("FAIL prefix_fields: got %h, required %h", o, e);
            end
        end
        sb.delete(); obs.delete();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_decode_back_to_back();
        test_backpressure();
        test_flush();
        test_prefix();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
